pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch for the pipelined RISC-V core.
- Advances the PC by 4 on each accepted fetch and holds it on a hazard stall.
- Redirects to the EX-stage branch target (pc_ex + (imm_ex << 1)) when Branch & Zero, and flushes the younger stages.
- Sits between the hazard/EX logic and instruction memory; replaces free-running next-PC selection with a stateful controller.

Parameters:
- XLEN, 64, datapath/PC width.
- RESET_PC, 64'd0, PC value loaded on reset.
- IMM_SHIFT, 1, left shift applied to imm_ex for the branch target.
- CNT_W, 32, width of the saturating redirect counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard unit request to hold IF.
- branch_ex  in  1  EX-stage instruction is a branch.
- zero_ex  in  1  ALU zero flag for the EX-stage branch.
- imm_ex  in  XLEN  signed branch immediate (pre-shift).
- pc_ex  in  XLEN  PC of the EX-stage instruction.
- imem_ready  in  1  instruction memory returns data this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (= current PC).
- if_valid  out  1  one-cycle pulse: fetch accepted into IF/ID.
- pc_if  out  XLEN  PC of the accepted fetch; valid when if_valid.
- flush  out  1  one-cycle pulse: kill IF/ID and ID/EX contents.
- misalign_err  out  1  sticky: redirect target not 4-byte aligned.
- redirect_cnt  out  CNT_W  number of taken redirects, saturating.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, state=BOOT.
  - imem_req, if_valid, flush, misalign_err = 0; redirect_cnt = 0; pc_if = 0.
  - rst overrides every other input.
- States:
  - BOOT: imem_req=0. Next state FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=pc.
  - REDIRECT: imem_req=0. Lasts one cycle while the in-flight response is discarded. Next state FETCH.
  - HALT: imem_req=0. Entered on a misaligned target; exited only by rst.
- taken = branch_ex & zero_ex, sampled only in FETCH and REDIRECT. It is ignored in BOOT and HALT.
- target = pc_ex + (imm_ex <<< IMM_SHIFT), two's-complement, truncated mod 2^XLEN. Negative imm wraps correctly.
- Priority within FETCH at each edge: taken > stall_i > imem_ready.
  - taken, target[1:0]==0:
    - pc<=target; flush=1 next cycle; redirect_cnt+=1 (holds at all-ones); state<=REDIRECT.
    - if_valid=0 even if imem_ready is high the same cycle; the response is dropped.
  - taken, target[1:0]!=0:
    - misalign_err<=1; pc unchanged; flush=1 next cycle; state<=HALT.
  - stall_i & !taken: pc held, if_valid=0. A concurrent imem_ready is dropped, and the same PC is re-requested next cycle.
  - imem_ready & !stall_i & !taken: if_valid=1 and pc_if=pc (registered, visible the next cycle); pc<=pc+4, wrapping past 2^XLEN-4 to 0.
  - none of the above: wait; pc held, if_valid=0.
- Taken branch in REDIRECT (back-to-back): handled as in FETCH. The newer target wins, flush pulses again, and the state stays REDIRECT for one more cycle.
- Outputs if_valid and flush are registered, so latency is 1 cycle from the causing edge. Neither is ever high for two consecutive cycles from a single event.
- Steady-state throughput is 1 fetch/cycle with imem_ready held high. A taken redirect costs 2 bubble cycles (REDIRECT + re-fetch).
- rst asserted mid-operation takes effect at the next edge from any state, including HALT. A pending flush is cancelled.

Decomposition:
- Shared package pc_pkg:
  - state enum: BOOT, FETCH, REDIRECT, HALT.
  - constant INSTR_BYTES=4.
  - localparams for XLEN and RESET_PC defaults.
- One sub-module, branch_target_calc (combinational): pc_ex, imm_ex → target, misaligned. It shares the new-PC arithmetic rule used elsewhere in the pipeline.
- The FSM, PC register and counter stay in pc_sequencer.

Test Plan:
1. Reset, imem_ready=1, no branch, stall_i=0 for 3 cycles → BOOT then FETCH; pc_if sequence 0, 4, 8 with if_valid high on each; flush=0.
2. FETCH at pc=12, stall_i=1 for 2 cycles with imem_ready=1 → if_valid=0 for both cycles, imem_addr stays 12; after release, pc_if=12 then 16.
3. Redirect: branch_ex=1, zero_ex=0, pc_ex=4 → no redirect, sequential fetch continues. Then branch_ex=1, zero_ex=1, pc_ex=8, imm_ex=16 → flush pulse, next imem_addr=40, redirect_cnt=1, one REDIRECT bubble.
4. Negative immediate: pc_ex=40, imm_ex=-4, taken → imem_addr=32 after the REDIRECT cycle; the same-cycle imem_ready response is dropped (if_valid=0).
5. Misaligned target: pc_ex=50, imm_ex=-10 → target=30, misalign_err=1 sticky, flush pulse, HALT with imem_req=0; rst then recovers to pc=0 with misalign_err=0.
6. Back-to-back taken branches in FETCH then REDIRECT (targets 64, then 128) → two flush pulses, final imem_addr=128, redirect_cnt=2. Separately, preload redirect_cnt to all-ones → it saturates and does not wrap.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
// The same instruction-size constant drives both PC advance and target alignment.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } seqState_t;

  localparam int          INSTR_BYTES      = 4;
  localparam int          XLEN_DEFAULT     = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'd0;

endpackage

// File: rtl/pc_sequencer_if.sv
// Groups the hazard/EX inputs and the instruction-memory/IF-ID outputs of the sequencer.
// The sequencer drives through 'master'; the surrounding pipeline connects through 'slave'.
interface pc_sequencer_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);

  logic             stall_i;
  logic             branch_ex;
  logic             zero_ex;
  logic [XLEN-1:0]  imm_ex;
  logic [XLEN-1:0]  pc_ex;
  logic             imem_ready;

  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             if_valid;
  logic [XLEN-1:0]  pc_if;
  logic             flush;
  logic             misalign_err;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    input  stall_i, branch_ex, zero_ex, imm_ex, pc_ex, imem_ready,
    output imem_req, imem_addr, if_valid, pc_if, flush, misalign_err, redirect_cnt
  );

  modport slave (
    output stall_i, branch_ex, zero_ex, imm_ex, pc_ex, imem_ready,
    input  imem_req, imem_addr, if_valid, pc_if, flush, misalign_err, redirect_cnt
  );

endinterface

// File: rtl/pc_sequencer_branch_target_calc.sv
// Combinational branch target: pc_ex + (imm_ex <<< IMM_SHIFT), wrapping mod 2^XLEN,
// plus a flag for targets that are not aligned to an instruction boundary.
module branch_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int IMM_SHIFT = 1
) (
  input  logic [XLEN-1:0] i_pcEx,
  input  logic [XLEN-1:0] i_immEx,
  output logic [XLEN-1:0] o_target,
  output logic            o_misaligned
);

  localparam int ALIGN_W = $clog2(INSTR_BYTES);

  logic [XLEN-1:0] w_shiftedImm;

  // Two's-complement add handles negative offsets without sign-extension tricks.
  assign w_shiftedImm = i_immEx << IMM_SHIFT;
  assign o_target     = i_pcEx + w_shiftedImm;
  assign o_misaligned = (o_target[ALIGN_W-1:0] != '0);

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register and fetch-sequencing FSM: sequential fetch, stall hold,
// taken-branch redirect with flush, sticky halt on a misaligned target.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter int              IMM_SHIFT = 1,
  parameter int              CNT_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  seqState_t        r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_pcIf;
  logic             r_imemReq;
  logic             r_ifValid;
  logic             r_flush;
  logic             r_misalignErr;
  logic [CNT_W-1:0] r_redirectCnt;

  logic [XLEN-1:0]  w_target;
  logic             w_misaligned;
  logic             w_taken;

  branch_target_calc #(
    .XLEN      (XLEN),
    .IMM_SHIFT (IMM_SHIFT)
  ) u_targetCalc (
    .i_pcEx       (bus.pc_ex),
    .i_immEx      (bus.imm_ex),
    .o_target     (w_target),
    .o_misaligned (w_misaligned)
  );

  assign w_taken = bus.branch_ex & bus.zero_ex;

  // Pulse outputs default low every cycle so a single event never stretches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_pcIf        <= '0;
      r_imemReq     <= 1'b0;
      r_ifValid     <= 1'b0;
      r_flush       <= 1'b0;
      r_misalignErr <= 1'b0;
      r_redirectCnt <= '0;
    end else begin
      r_ifValid <= 1'b0;
      r_flush   <= 1'b0;
      unique case (r_state)
        BOOT: begin
          r_state   <= FETCH;
          r_imemReq <= 1'b1;
        end
        FETCH, REDIRECT: begin
          if (w_taken) begin
            r_flush   <= 1'b1;
            r_imemReq <= 1'b0;
            if (w_misaligned) begin
              r_misalignErr <= 1'b1;
              r_state       <= HALT;
            end else begin
              r_pc    <= w_target;
              r_state <= REDIRECT;
              if (r_redirectCnt != '1) begin
                r_redirectCnt <= r_redirectCnt + CNT_W'(1);
              end
            end
          end else if (r_state == REDIRECT) begin
            // The response to the pre-redirect request has been discarded; resume fetch.
            r_state   <= FETCH;
            r_imemReq <= 1'b1;
          end else if (!bus.stall_i && bus.imem_ready) begin
            r_ifValid <= 1'b1;
            r_pcIf    <= r_pc;
            r_pc      <= r_pc + XLEN'(INSTR_BYTES);
          end
        end
        HALT: begin
          r_imemReq <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req     = r_imemReq;
  assign bus.imem_addr    = r_pc;
  assign bus.if_valid     = r_ifValid;
  assign bus.pc_if        = r_pcIf;
  assign bus.flush        = r_flush;
  assign bus.misalign_err = r_misalignErr;
  assign bus.redirect_cnt = r_redirectCnt;

endmodule
